// File: rtl/bcd_entry_pkg.sv
// Shared types, segment constants and helpers for decimal operand entry and display.
package bcd_entry_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned VALUE_W = 7;

  // Largest decimal digit a single entry may carry.
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  typedef enum logic [1:0] {
    WAIT_TENS = 2'd0,
    WAIT_ONES = 2'd1,
    DONE      = 2'd2
  } entry_state_t;

  // Seven-segment codes, bit order G F E D C B A, active-low.
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // True when the value is a legal BCD digit.
  function automatic logic is_digit(input logic [DIGIT_W-1:0] d);
    return d <= DIGIT_MAX;
  endfunction

  // Segment pattern for one BCD digit; non-digits show blank.
  function automatic logic [SEG_W-1:0] seg7(input logic [DIGIT_W-1:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // tens*10 + ones using shifts; 99 fits in 7 bits so no overflow is possible.
  function automatic logic [VALUE_W-1:0] bcd_to_bin(input logic [DIGIT_W-1:0] tens,
                                                    input logic [DIGIT_W-1:0] ones);
    logic [VALUE_W-1:0] t;
    t = VALUE_W'(tens);
    return (t << 3) + (t << 1) + VALUE_W'(ones);
  endfunction

endpackage

// File: rtl/key_edge.sv
// Push-button front end: 2-flop synchronizer plus falling-edge detector.
// A key already held when reset releases is ignored until it has been
// seen released, so holding a key through reset never produces a pulse.
module key_edge (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic fall_c
);

  logic       sync1;
  logic       sync2;
  logic       prev;
  logic [1:0] live;
  logic       armed;

  // Synchronize, keep previous sample, and arm once a real released level arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
      live  <= 2'b00;
      armed <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      prev  <= sync2;
      live  <= {live[0], 1'b1};
      armed <= armed | (live[1] & sync2);
    end
  end

  assign fall_c = armed & prev & ~sync2;

endmodule

// File: rtl/bcd_entry_unit.sv
// Two-digit decimal entry: digits confirmed by KEY_ENTER, converted to binary,
// echoed on two active-low seven-segment displays.
module bcd_entry_unit
  import bcd_entry_pkg::*;
(
  input  logic         CLOCK_50,
  input  logic         RESET,
  input  logic [3:0]   SW,
  input  logic         KEY_ENTER,
  input  logic         KEY_CLEAR,
  output logic [6:0]   VALUE,
  output logic         VALID,
  output logic         ERROR,
  output logic [6:0]   HEX1,
  output logic [6:0]   HEX0
);

  logic               enter_c;
  logic               clear_c;
  entry_state_t       state;
  logic [DIGIT_W-1:0] tens;

  key_edge u_enter_edge (
    .clk    (CLOCK_50),
    .reset  (RESET),
    .key_n  (KEY_ENTER),
    .fall_c (enter_c)
  );

  key_edge u_clear_edge (
    .clk    (CLOCK_50),
    .reset  (RESET),
    .key_n  (KEY_CLEAR),
    .fall_c (clear_c)
  );

  // Entry FSM with registered value, strobe, error flag and display echo.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state <= WAIT_TENS;
      tens  <= '0;
      VALUE <= '0;
      VALID <= 1'b0;
      ERROR <= 1'b0;
      HEX1  <= SEG_BLANK;
      HEX0  <= SEG_BLANK;
    end else begin
      VALID <= 1'b0;
      if (clear_c) begin
        // Clear beats a simultaneous enter.
        state <= WAIT_TENS;
        tens  <= '0;
        VALUE <= '0;
        ERROR <= 1'b0;
        HEX1  <= SEG_BLANK;
        HEX0  <= SEG_BLANK;
      end else if (enter_c) begin
        case (state)
          WAIT_TENS, DONE: begin
            if (is_digit(SW)) begin
              tens  <= SW;
              ERROR <= 1'b0;
              state <= WAIT_ONES;
              HEX1  <= seg7(SW);
              HEX0  <= SEG_BLANK;
            end else begin
              // A bad first digit abandons the old number's echo but keeps VALUE.
              ERROR <= 1'b1;
              state <= WAIT_TENS;
              HEX1  <= SEG_BLANK;
              HEX0  <= SEG_BLANK;
            end
          end
          WAIT_ONES: begin
            if (is_digit(SW)) begin
              VALUE <= bcd_to_bin(tens, SW);
              VALID <= 1'b1;
              ERROR <= 1'b0;
              state <= DONE;
              HEX0  <= seg7(SW);
            end else begin
              ERROR <= 1'b1;
            end
          end
          default: begin
            state <= WAIT_TENS;
            HEX1  <= SEG_BLANK;
            HEX0  <= SEG_BLANK;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/bcd_entry_unit.md
# bcd_entry_unit

Sequential decimal operand-entry block for the switch/seven-segment lab datapath, the input-side counterpart of the binary-to-decimal display path. The operator keys in a two-digit decimal number one digit at a time on SW[3:0], confirming each digit with KEY_ENTER. The block converts the digits to a 7-bit binary value and pulses VALID, so the value can feed the adder. It echoes the digits on two active-low seven-segment displays.

## Interface
- No parameters; widths fixed.
- CLOCK_50  in  1  system clock, all state on rising edge
- RESET  in  1  synchronous, active-high
- SW  in  4  BCD digit under entry
- KEY_ENTER  in  1  active-low push button, board-debounced, asynchronous to CLOCK_50
- KEY_CLEAR  in  1  active-low push button, board-debounced, asynchronous to CLOCK_50
- VALUE  out  7  binary result, tens*10+ones, range 0..99
- VALID  out  1  one-cycle pulse when VALUE is updated
- ERROR  out  1  sticky flag: last confirmed digit was >9
- HEX1  out  7  tens echo, bit order G F E D C B A, active-low
- HEX0  out  7  ones echo, same format

## Operation
- Each key passes through a 2-flop synchronizer, then a falling-edge detector (previous-sample flop). The detector produces one internal pulse per press, regardless of hold length.
- FSM states and transitions:
  - WAIT_TENS: enter pulse with SW<=9 latches tens, clears ERROR, goes to WAIT_ONES. Enter pulse with SW>9 sets ERROR and stays in WAIT_TENS.
  - WAIT_ONES: enter pulse with SW<=9 latches ones, registers VALUE, asserts VALID, clears ERROR, goes to DONE. Enter pulse with SW>9 sets ERROR, keeps tens, and stays in WAIT_ONES.
  - DONE: VALUE held. An enter pulse starts a new number, treated exactly as a WAIT_TENS entry. VALUE keeps its old value until the new ones digit is confirmed.
- Clear pulse, from any state: goes to WAIT_TENS; VALUE=0, ERROR=0, tens=ones=0, both displays blank, VALID=0.
- Clear and enter pulses in the same cycle: clear wins and enter is discarded.
- Arithmetic: VALUE = (tens<<3) + (tens<<1) + ones. Computed at 7 bits with no overflow possible (max 99 = 7'h63).
- Display echo:
  - WAIT_TENS: HEX1 and HEX0 blank (7'h7F).
  - WAIT_ONES: HEX1 shows the tens digit; HEX0 blank.
  - DONE: HEX1 shows tens, HEX0 shows ones. A leading zero is displayed, not blanked.
- Digit segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- ERROR does not alter the displays.

## Timing
- Reset values: state WAIT_TENS, VALUE=0, VALID=0, ERROR=0, HEX0=HEX1=7'h7F. Synchronizer and edge flops reset to 1 (released), so no pulse occurs after reset even if a key is held.
- Key latency: KEY sampled low at edge k; the edge pulse is valid between edges k+1 and k+2; FSM, VALUE, VALID, ERROR and HEX update at edge k+2.
- VALID is high for exactly the one cycle after edge k+2, coincident with the new VALUE.
- All outputs are registered; no combinational path from SW or KEY to any output.
- Minimum press spacing: one release cycle between presses is sufficient; back-to-back presses are each honoured.
- RESET asserted mid-entry aborts at the next edge to the reset values; no VALID is emitted.

## Structure
- Shared package bcd_entry_pkg holds:
  - the FSM state enum (WAIT_TENS, WAIT_ONES, DONE)
  - the 10 digit segment constants plus SEG_BLANK=7'h7F, in G..A active-low order, reusable by the display side
- One sub-module, key_edge: 2-flop synchronizer plus falling-edge detector, synchronous active-high reset to released, instantiated twice.
- Segment lookup is a function in the package, not a module.

## Test plan
- Reset with KEY_ENTER held low -> no VALID; HEX0=HEX1=7'h7F, VALUE=0, ERROR=0 for 20 cycles after release of RESET.
- Enter 4, then 7 -> VALUE=7'h2F and VALID for one cycle, 2 cycles after the second press sample. HEX1=0011001, HEX0=1111000.
- Enter 9, 9 -> VALUE=7'h63. Then enter 0 -> HEX1=1000000, HEX0 blank, VALUE still 7'h63. Then enter 5 -> VALUE=7'h05.
- SW=4'hC pressed in WAIT_TENS -> ERROR=1, state unchanged, HEX blank. Then SW=3 pressed -> ERROR=0 and HEX1=0110000.
- Enter 6, then KEY_CLEAR and KEY_ENTER falling together with SW=2 -> WAIT_TENS, displays blank, VALUE=0, no VALID.
- KEY_ENTER held low 1000 cycles with SW=1 -> exactly one state advance. RESET during WAIT_ONES -> all reset values at the next edge.
